axi_dual_master_arbiter: RTL

Two-master to one-slave AXI4 arbiter that shares the single AXI4 slave port of ddr_sdram_ctrl between two requesters, e.g. a DMA engine and a self-test master. The write path (AW/W/B) and the read path (AR/R) are arbitrated independently, each with its own round-robin state machine. A grant is held for a whole burst. The block sits in the clk domain, between the masters and ddr_sdram_ctrl.

---
 rtl/axi_dual_master_arbiter.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_dual_master_arbiter.sv
// ---------------------------------------------------------------------------
// axi_dual_master_arbiter
//
// Shares one AXI4 slave port between two masters. The write path (AW/W/B)
// and the read path (AR/R) each have their own round-robin state machine, so
// a write burst and a read burst can be in flight at the same time, even
// from the same master. A grant is held from the address phase until the
// burst completes (B handshake for writes, last R beat for reads).
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   m_aw* / m_w* / m_b*    per-master write channels (bit/slice i = master i)
//   m_ar* / m_r*           per-master read channels (m_rdata shared)
//   s_aw* / s_w* / s_b*    slave write channels
//   s_ar* / s_r*           slave read channels
//   wgrant, rgrant         one-hot owner of the write / read path, 0 if idle
//   proto_err              sticky: wlast seen on the wrong beat
// ---------------------------------------------------------------------------
module axi_dual_master_arbiter #(
    parameter int A_WIDTH = 26,
    parameter int D_WIDTH = 16
) (
    input  logic                   rstn,
    input  logic                   clk,
    // master write address
    input  logic [1:0]             m_awvalid,
    output logic [1:0]             m_awready,
    input  logic [2*A_WIDTH-1:0]   m_awaddr,
    input  logic [15:0]            m_awlen,
    // master write data
    input  logic [1:0]             m_wvalid,
    input  logic [1:0]             m_wlast,
    input  logic [2*D_WIDTH-1:0]   m_wdata,
    output logic [1:0]             m_wready,
    // master write response
    output logic [1:0]             m_bvalid,
    input  logic [1:0]             m_bready,
    // master read address
    input  logic [1:0]             m_arvalid,
    input  logic [2*A_WIDTH-1:0]   m_araddr,
    input  logic [15:0]            m_arlen,
    output logic [1:0]             m_arready,
    // master read data
    output logic [1:0]             m_rvalid,
    output logic [1:0]             m_rlast,
    output logic [D_WIDTH-1:0]     m_rdata,
    input  logic [1:0]             m_rready,
    // slave write address
    output logic                   s_awvalid,
    output logic [A_WIDTH-1:0]     s_awaddr,
    output logic [7:0]             s_awlen,
    input  logic                   s_awready,
    // slave write data
    output logic                   s_wvalid,
    output logic                   s_wlast,
    output logic [D_WIDTH-1:0]     s_wdata,
    input  logic                   s_wready,
    // slave write response
    input  logic                   s_bvalid,
    output logic                   s_bready,
    // slave read address
    output logic                   s_arvalid,
    output logic [A_WIDTH-1:0]     s_araddr,
    output logic [7:0]             s_arlen,
    input  logic                   s_arready,
    // slave read data
    input  logic                   s_rvalid,
    input  logic                   s_rlast,
    input  logic [D_WIDTH-1:0]     s_rdata,
    output logic                   s_rready,
    // status
    output logic [1:0]             wgrant,
    output logic [1:0]             rgrant,
    output logic                   proto_err
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rstate_t;

    wstate_t     wstate_q;
    rstate_t     rstate_q;
    logic [1:0]  wgrant_q;
    logic [1:0]  rgrant_q;
    logic        wptr_q;
    logic        rptr_q;
    logic [7:0]  wcnt_q;
    logic [7:0]  wcnt_max_q;
    logic        proto_err_q;

    logic        widx_s;
    logic        ridx_s;

    // Round-robin pick: a lone requester always wins; on contention the
    // master named by ptr wins. Returns a one-hot grant.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        logic [1:0] g;
        case (req)
            2'b11:   g = ptr ? 2'b10 : 2'b01;
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    // Grants are one-hot, so bit 1 is the index of the owner.
    assign widx_s    = wgrant_q[1];
    assign ridx_s    = rgrant_q[1];
    assign wgrant    = wgrant_q;
    assign rgrant    = rgrant_q;
    assign proto_err = proto_err_q;

    // Payloads follow the registered grant; only valid/ready are state-gated.
    assign s_awaddr = widx_s ? m_awaddr[2*A_WIDTH-1:A_WIDTH] : m_awaddr[A_WIDTH-1:0];
    assign s_awlen  = widx_s ? m_awlen[15:8] : m_awlen[7:0];
    assign s_wdata  = widx_s ? m_wdata[2*D_WIDTH-1:D_WIDTH] : m_wdata[D_WIDTH-1:0];
    assign s_araddr = ridx_s ? m_araddr[2*A_WIDTH-1:A_WIDTH] : m_araddr[A_WIDTH-1:0];
    assign s_arlen  = ridx_s ? m_arlen[15:8] : m_arlen[7:0];
    assign m_rdata  = s_rdata;

    // Write path FSM: grant, beat counting, wlast checking and pointer update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q    <= W_IDLE;
            wgrant_q    <= 2'b00;
            wptr_q      <= 1'b0;
            wcnt_q      <= 8'd0;
            wcnt_max_q  <= 8'd0;
            proto_err_q <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (|m_awvalid) begin
                        wgrant_q <= rr_pick(m_awvalid, wptr_q);
                        wstate_q <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    // A request withdrawn before acceptance never reaches the slave.
                    if (!m_awvalid[widx_s]) begin
                        wgrant_q <= 2'b00;
                        wstate_q <= W_IDLE;
                    end else if (s_awready) begin
                        wcnt_max_q <= s_awlen;
                        wcnt_q     <= 8'd0;
                        wstate_q   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_wvalid && s_wready) begin
                        wcnt_q <= wcnt_q + 8'd1;
                        // wlast must coincide exactly with the final beat.
                        if (s_wlast != (wcnt_q == wcnt_max_q)) begin
                            proto_err_q <= 1'b1;
                        end
                        if (s_wlast) begin
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_bvalid && s_bready) begin
                        wptr_q   <= ~widx_s;
                        wgrant_q <= 2'b00;
                        wstate_q <= W_IDLE;
                    end
                end
                default: begin
                    wgrant_q <= 2'b00;
                    wstate_q <= W_IDLE;
                end
            endcase
        end
    end

    // Read path FSM: grant and pointer update on the last R beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate_q <= R_IDLE;
            rgrant_q <= 2'b00;
            rptr_q   <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (|m_arvalid) begin
                        rgrant_q <= rr_pick(m_arvalid, rptr_q);
                        rstate_q <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (!m_arvalid[ridx_s]) begin
                        rgrant_q <= 2'b00;
                        rstate_q <= R_IDLE;
                    end else if (s_arready) begin
                        rstate_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_rvalid && s_rready && s_rlast) begin
                        rptr_q   <= ~ridx_s;
                        rgrant_q <= 2'b00;
                        rstate_q <= R_IDLE;
                    end
                end
                default: begin
                    rgrant_q <= 2'b00;
                    rstate_q <= R_IDLE;
                end
            endcase
        end
    end

    // Write handshake routing between the granted master and the slave.
    always_comb begin
        m_awready = 2'b00;
        m_wready  = 2'b00;
        m_bvalid  = 2'b00;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_wlast   = 1'b0;
        s_bready  = 1'b0;
        case (wstate_q)
            W_ADDR: begin
                s_awvalid         = m_awvalid[widx_s];
                m_awready[widx_s] = s_awready;
            end
            W_DATA: begin
                s_wvalid         = m_wvalid[widx_s];
                s_wlast          = m_wlast[widx_s];
                m_wready[widx_s] = s_wready;
            end
            W_RESP: begin
                m_bvalid[widx_s] = s_bvalid;
                s_bready         = m_bready[widx_s];
            end
            default: begin
                s_awvalid = 1'b0;
            end
        endcase
    end

    // Read handshake routing between the granted master and the slave.
    always_comb begin
        m_arready = 2'b00;
        m_rvalid  = 2'b00;
        m_rlast   = 2'b00;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        case (rstate_q)
            R_ADDR: begin
                s_arvalid         = m_arvalid[ridx_s];
                m_arready[ridx_s] = s_arready;
            end
            R_DATA: begin
                m_rvalid[ridx_s] = s_rvalid;
                m_rlast[ridx_s]  = s_rlast;
                s_rready         = m_rready[ridx_s];
            end
            default: begin
                s_arvalid = 1'b0;
            end
        endcase
    end

endmodule
